// File: rtl/audio_pkg.sv
// audio_pkg: clip table, clip index type and player state encoding
// shared by the audio clip player files.
package audio_pkg;

    typedef logic [1:0] clip_t;

    typedef enum logic [1:0] {IDLE, PRIME, WAIT_TICK, EMIT} state_t;

    // Inclusive start/end addresses of the four clips packed in the sample ROM
    localparam logic [31:0] CLIP_START [4] = '{32'd0, 32'd16396, 32'd66983, 32'd83255};
    localparam logic [31:0] CLIP_END   [4] = '{32'd16395, 32'd66982, 32'd83254, 32'd137138};

endpackage

// File: rtl/audio_tick_gen.sv
// audio_tick_gen: sample-rate divider, counts 0..DIV-1 and pulses tick on
// the last count; clr holds it at zero.
module audio_tick_gen #(
    parameter int DIV = 1200
)(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt;

    assign tick = cnt == W'(DIV - 1);

    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
endmodule

// File: rtl/audio_clip_player.sv
// audio_clip_player: walks one ROM clip at the sample rate and feeds the
// Audio_Controller write port. Define AUDIO_PLAYER_UNDERRUN_EN for underrun_cnt.
module audio_clip_player
    import audio_pkg::*;
#(
    parameter int ADDR_W   = 18,
    parameter int SAMPLE_W = 6,
    parameter int TICK_DIV = 1200,
    parameter int ROM_LAT  = 2
)(
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                play_req,
    input  logic [1:0]          clip_sel,
    input  logic                loop_en,
    input  logic                stop_req,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [SAMPLE_W-1:0] rom_q,
    input  logic                audio_out_allowed,
    output logic                write_audio_out,
    output logic [31:0]         left_channel_audio_out,
    output logic                busy,
    output logic                clip_done
`ifdef AUDIO_PLAYER_UNDERRUN_EN
    ,
    output logic [15:0]         underrun_cnt
`endif
);
    state_t state, nxt;
    logic [ADDR_W-1:0] start_a, end_a;
    logic [SAMPLE_W-1:0] sample;
    logic [31:0] last;
    logic [1:0] pcnt;
    logic tick, tick_clr, fire, at_end, restart;

    assign tick_clr = state == IDLE || play_req;
    assign at_end   = rom_addr == end_a;
    assign restart  = play_req && !stop_req;

    audio_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk (CLOCK_50),
        .rst (reset),
        .clr (tick_clr),
        .tick(tick)
    );

    always_ff @(posedge CLOCK_50 or posedge reset)
        if (reset)
            state <= IDLE;
        else
            state <= nxt;

    // A restart or stop in EMIT suppresses the strobe so nothing half-issued leaks out
    always_comb begin
        fire = state == EMIT && audio_out_allowed && !play_req && !stop_req;
        nxt = stop_req ? IDLE :
              play_req ? PRIME :
              state == PRIME ? (pcnt == 2'(ROM_LAT) ? WAIT_TICK : PRIME) :
              state == WAIT_TICK ? (tick ? EMIT : WAIT_TICK) :
              fire ? (at_end && !loop_en ? IDLE : PRIME) : state;
        write_audio_out = fire;
        clip_done = fire && at_end && !loop_en;
        busy = state != IDLE;
        left_channel_audio_out = fire ? {sample, {(32 - SAMPLE_W){1'b0}}} : last;
    end

    // rom_q is captured once ROM_LAT cycles have fully elapsed after the address moved
    always_ff @(posedge CLOCK_50 or posedge reset)
        if (reset) begin
            rom_addr <= '0;
            start_a  <= '0;
            end_a    <= '0;
            sample   <= '0;
            last     <= '0;
            pcnt     <= '0;
        end else begin
            pcnt <= (state == PRIME && nxt == PRIME && !play_req) ? pcnt + 2'd1 : 2'd0;
            if (state == PRIME && nxt == WAIT_TICK)
                sample <= rom_q;
            if (fire)
                last <= {sample, {(32 - SAMPLE_W){1'b0}}};
            if (restart) begin
                start_a  <= ADDR_W'(CLIP_START[clip_sel]);
                end_a    <= ADDR_W'(CLIP_END[clip_sel]);
                rom_addr <= ADDR_W'(CLIP_START[clip_sel]);
            end else if (fire && !at_end)
                rom_addr <= rom_addr + ADDR_W'(1);
            else if (fire && loop_en)
                rom_addr <= start_a;
        end

`ifdef AUDIO_PLAYER_UNDERRUN_EN
    always_ff @(posedge CLOCK_50 or posedge reset)
        if (reset)
            underrun_cnt <= '0;
        else if (play_req)
            underrun_cnt <= '0;
        else if (state == EMIT && tick && underrun_cnt != 16'hFFFF)
            underrun_cnt <= underrun_cnt + 16'd1;
`endif
endmodule
